// File: rtl/ub_pkg.sv
// Shared types and defaults for the unified buffer.
// Provides the read-stream state encoding, default parameter values and the
// burst-size helper used to size the accumulator write lanes.
package ub_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HOLD
  } rd_state_t;

  localparam int UB_DATA_W    = 32;
  localparam int UB_DEPTH     = 64;
  localparam int UB_NUM_ACC   = 2;
  localparam int UB_ACC_WORDS = 2;
  localparam int UB_RD_LANES  = 2;

  // Words committed by one accumulator burst.
  function automatic int burst_size(input int num_acc, input int acc_words);
    return num_acc * acc_words;
  endfunction

endpackage

// File: rtl/ub_mem_array.sv
// DEPTH x DATA_W storage for the unified buffer.
// Ports:
//   clk, reset          clock, async active-low reset (read register only)
//   burst_we            commit B consecutive words starting at burst_base
//   burst_base          first address of the burst (never wraps)
//   burst_data          B words, lane k at slice k
//   host_we/host_addr/host_wdata  single-word preload write
//   rd_en, rd_addr      register RD_LANES words from mem[(rd_addr+j) mod DEPTH]
//   rd_data             registered read lanes, lane j at slice j
module ub_mem_array #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 64,
  parameter int AW       = 6,
  parameter int B        = 4,
  parameter int RD_LANES = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         burst_we,
  input  logic [AW-1:0]                burst_base,
  input  logic [B*DATA_W-1:0]          burst_data,
  input  logic                         host_we,
  input  logic [AW-1:0]                host_addr,
  input  logic [DATA_W-1:0]            host_wdata,
  input  logic                         rd_en,
  input  logic [AW-1:0]                rd_addr,
  output logic [RD_LANES*DATA_W-1:0]   rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Burst lanes are assigned after the host lane so the burst wins on overlap.
  always_ff @(posedge clk) begin
    if (host_we) begin
      mem[host_addr] <= host_wdata;
    end
    if (burst_we) begin
      for (int unsigned k = 0; k < B; k++) begin
        mem[burst_base + AW'(k)] <= burst_data[k*DATA_W +: DATA_W];
      end
    end
  end

  // Address arithmetic is AW bits wide, so lane addresses wrap modulo DEPTH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data <= '0;
    end else if (rd_en) begin
      for (int unsigned j = 0; j < RD_LANES; j++) begin
        rd_data[j*DATA_W +: DATA_W] <= mem[rd_addr + AW'(j)];
      end
    end
  end

endmodule

// File: rtl/unified_buffer_mc.sv
// Multi-channel unified buffer between the accumulator bank and input setup.
// Ports:
//   clk, reset             clock, async active-low reset
//   acc_valid, acc_data    accumulator burst (commits when all valid and acc_ready)
//   acc_ready              a full burst fits below DEPTH
//   wr_clr                 sync clear of wr_ptr and overflow (beats a burst)
//   host_we/addr/wdata     single-word preload write
//   rd_start/addr/len      start a read stream of rd_len beats (IDLE only)
//   rd_data, rd_valid, rd_ready   RD_LANES-word beats under valid/ready
//   rd_busy, rd_done       stream active / one-cycle completion pulse
//   wr_ptr, full, overflow next free address, wr_ptr==DEPTH, sticky drop flag
module unified_buffer_mc
  import ub_pkg::*;
#(
  parameter int DATA_W    = UB_DATA_W,
  parameter int DEPTH     = UB_DEPTH,
  parameter int NUM_ACC   = UB_NUM_ACC,
  parameter int ACC_WORDS = UB_ACC_WORDS,
  parameter int RD_LANES  = UB_RD_LANES,
  parameter int AW        = $clog2(DEPTH)
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NUM_ACC-1:0]                  acc_valid,
  input  logic [NUM_ACC*ACC_WORDS*DATA_W-1:0] acc_data,
  output logic                                acc_ready,
  input  logic                                wr_clr,
  input  logic                                host_we,
  input  logic [AW-1:0]                       host_addr,
  input  logic [DATA_W-1:0]                   host_wdata,
  input  logic                                rd_start,
  input  logic [AW-1:0]                       rd_addr,
  input  logic [AW:0]                         rd_len,
  output logic [RD_LANES*DATA_W-1:0]          rd_data,
  output logic                                rd_valid,
  input  logic                                rd_ready,
  output logic                                rd_busy,
  output logic                                rd_done,
  output logic [AW:0]                         wr_ptr,
  output logic                                full,
  output logic                                overflow
);

  localparam int B = burst_size(NUM_ACC, ACC_WORDS);
  localparam logic [AW:0] DEPTH_V     = (AW+1)'(DEPTH);
  localparam logic [AW:0] B_V         = (AW+1)'(B);
  localparam logic [AW:0] READY_LIMIT = (AW+1)'(DEPTH - B);

  logic      all_valid;
  logic      burst_we;
  rd_state_t state;
  logic [AW-1:0] addr;
  logic [AW:0]   beats_left;

  assign all_valid = &acc_valid;
  assign full      = (wr_ptr == DEPTH_V);
  // Free space >= B expressed as a compare against DEPTH-B, avoiding a subtract.
  assign acc_ready = (wr_ptr <= READY_LIMIT);
  assign burst_we  = all_valid && acc_ready && !wr_clr;
  assign rd_busy   = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      overflow <= 1'b0;
    end else if (wr_clr) begin
      wr_ptr   <= '0;
      overflow <= 1'b0;
    end else if (all_valid) begin
      if (acc_ready) begin
        wr_ptr <= wr_ptr + B_V;
      end else begin
        overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      addr       <= '0;
      beats_left <= '0;
      rd_valid   <= 1'b0;
      rd_done    <= 1'b0;
    end else begin
      rd_done <= 1'b0;
      case (state)
        IDLE: begin
          if (rd_start) begin
            if (rd_len != '0) begin
              addr       <= rd_addr;
              beats_left <= rd_len;
              state      <= FETCH;
            end else begin
              rd_done <= 1'b1;
            end
          end
        end
        FETCH: begin
          rd_valid <= 1'b1;
          state    <= HOLD;
        end
        HOLD: begin
          if (rd_ready) begin
            rd_valid   <= 1'b0;
            addr       <= addr + AW'(RD_LANES);
            beats_left <= beats_left - (AW+1)'(1);
            if (beats_left == (AW+1)'(1)) begin
              state   <= IDLE;
              rd_done <= 1'b1;
            end else begin
              state <= FETCH;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  ub_mem_array #(
    .DATA_W  (DATA_W),
    .DEPTH   (DEPTH),
    .AW      (AW),
    .B       (B),
    .RD_LANES(RD_LANES)
  ) u_mem (
    .clk       (clk),
    .reset     (reset),
    .burst_we  (burst_we),
    .burst_base(wr_ptr[AW-1:0]),
    .burst_data(acc_data),
    .host_we   (host_we),
    .host_addr (host_addr),
    .host_wdata(host_wdata),
    .rd_en     (state == FETCH),
    .rd_addr   (addr),
    .rd_data   (rd_data)
  );

endmodule
